// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: MIPS decode/operand fetch with EX/MEM forwarding, load-use stall
// and a one-entry valid/ready output register feeding execute.
module operand_fetch_stage #(
   parameter logic NOP_ON_UNKNOWN = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instruction,
   input  logic [31:0] in_pc,
   output logic        read_enable_a,
   output logic [4:0]  read_address_a,
   input  logic [31:0] read_data_a,
   output logic        read_enable_b,
   output logic [4:0]  read_address_b,
   input  logic [31:0] read_data_b,
   input  logic        ex_write_enable,
   input  logic [4:0]  ex_write_address,
   input  logic [31:0] ex_write_data,
   input  logic        ex_is_load,
   input  logic        mem_write_enable,
   input  logic [4:0]  mem_write_address,
   input  logic [31:0] mem_write_data,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [5:0]  out_opcode,
   output logic [5:0]  out_funct,
   output logic [31:0] out_operand_a,
   output logic [31:0] out_operand_b,
   output logic [31:0] out_store_data,
   output logic        out_write_enable,
   output logic [4:0]  out_write_address,
   output logic        out_is_load
);
   logic [5:0]  w_op;
   logic [4:0]  w_rs, w_rt, w_rd, w_dest, w_waddr;
   logic [15:0] w_imm;
   logic        w_is_r, w_is_log, w_is_addiu, w_is_lui, w_is_lw, w_is_sw, w_known;
   logic        w_use_a, w_use_b, w_ld_hit_a, w_ld_hit_b, w_stall, w_load, w_we;
   logic [31:0] w_src_a, w_src_b, w_op_a, w_op_b, w_store;
   logic [5:0]  w_funct;

   logic        r_valid, r_we, r_is_load;
   logic [31:0] r_pc, r_a, r_b, r_store;
   logic [5:0]  r_opcode, r_funct;
   logic [4:0]  r_waddr;

   assign w_op  = in_instruction[31:26];
   assign w_rs  = in_instruction[25:21];
   assign w_rt  = in_instruction[20:16];
   assign w_rd  = in_instruction[15:11];
   assign w_imm = in_instruction[15:0];

   assign w_is_r     = w_op == 6'h00;
   assign w_is_log   = w_op == 6'h0C || w_op == 6'h0D || w_op == 6'h0E;
   assign w_is_addiu = w_op == 6'h09;
   assign w_is_lui   = w_op == 6'h0F;
   assign w_is_lw    = w_op == 6'h23;
   assign w_is_sw    = w_op == 6'h2B;
   assign w_known    = w_is_r | w_is_log | w_is_addiu | w_is_lui | w_is_lw | w_is_sw;

   assign w_use_a = in_valid & (w_is_r | w_is_log | w_is_addiu | w_is_lw | w_is_sw);
   assign w_use_b = in_valid & (w_is_r | w_is_sw);

   assign read_enable_a  = w_use_a;
   assign read_address_a = w_rs;
   assign read_enable_b  = w_use_b;
   assign read_address_b = w_rt;

   // A pending load in EX cannot forward; it falls through to MEM/regfile and the stall covers it.
   assign w_src_a = (w_rs == 5'd0) ? 32'd0 :
                    (ex_write_enable && !ex_is_load && ex_write_address == w_rs) ? ex_write_data :
                    (mem_write_enable && mem_write_address == w_rs) ? mem_write_data : read_data_a;
   assign w_src_b = (w_rt == 5'd0) ? 32'd0 :
                    (ex_write_enable && !ex_is_load && ex_write_address == w_rt) ? ex_write_data :
                    (mem_write_enable && mem_write_address == w_rt) ? mem_write_data : read_data_b;

   assign w_ld_hit_a = w_use_a && ex_is_load && ex_write_enable && ex_write_address != 5'd0 && ex_write_address == w_rs;
   assign w_ld_hit_b = w_use_b && ex_is_load && ex_write_enable && ex_write_address != 5'd0 && ex_write_address == w_rt;
   assign w_stall    = w_ld_hit_a | w_ld_hit_b;

   assign in_ready = flush | ((!r_valid | out_ready) & !w_stall);
   assign w_load   = in_valid & in_ready & !flush & (w_known | NOP_ON_UNKNOWN);

   assign w_op_a  = (w_is_lui | !w_known) ? 32'd0 : w_src_a;
   assign w_op_b  = w_is_r ? w_src_b :
                    w_is_log ? {16'd0, w_imm} :
                    (w_is_addiu | w_is_lw | w_is_sw) ? {{16{w_imm[15]}}, w_imm} :
                    w_is_lui ? {w_imm, 16'd0} : 32'd0;
   assign w_store = w_is_sw ? w_src_b : 32'd0;
   assign w_dest  = w_is_r ? w_rd : w_rt;
   assign w_we    = (w_is_r | w_is_log | w_is_addiu | w_is_lui | w_is_lw) && w_dest != 5'd0;
   assign w_waddr = w_we ? w_dest : 5'd0;
   assign w_funct = w_is_r ? in_instruction[5:0] : 6'd0;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_valid   <= 1'b0;
         r_pc      <= 32'd0;
         r_opcode  <= 6'd0;
         r_funct   <= 6'd0;
         r_a       <= 32'd0;
         r_b       <= 32'd0;
         r_store   <= 32'd0;
         r_we      <= 1'b0;
         r_waddr   <= 5'd0;
         r_is_load <= 1'b0;
      end else if (flush) begin
         r_valid <= 1'b0;
      end else if (w_load) begin
         r_valid   <= 1'b1;
         r_pc      <= in_pc;
         r_opcode  <= w_op;
         r_funct   <= w_funct;
         r_a       <= w_op_a;
         r_b       <= w_op_b;
         r_store   <= w_store;
         r_we      <= w_we;
         r_waddr   <= w_waddr;
         r_is_load <= w_is_lw;
      end else if (out_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign out_valid         = r_valid;
   assign out_pc            = r_pc;
   assign out_opcode        = r_opcode;
   assign out_funct         = r_funct;
   assign out_operand_a     = r_a;
   assign out_operand_b     = r_b;
   assign out_store_data    = r_store;
   assign out_write_enable  = r_we;
   assign out_write_address = r_waddr;
   assign out_is_load       = r_is_load;
endmodule
